// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, message-granular arbiter that shares one UART TX FIFO among N_REQ requesters.
// Latency: grant 1 Clk after a valid is seen in IDLE; handshake to uart_send 1 Clk; up to one byte per Clk.
// Backpressure: req_ready stays low without a FIFO credit; a credit returns on each synchronised uart_is_busy rise.
//
// Optional feature: define UART_TX_ARB_TAG_EN to emit a header byte (8'hA0 | grant_id)
// through a TAG state between the grant and the first payload byte.
//
// Ports:
//   Clk, Rst_n                  clock, asynchronous active-low reset
//   req_valid/req_data/req_last per-requester byte stream (byte i at req_data[8i+7:8i])
//   req_ready                   per-requester accept, only ever set for the owner
//   grant_active, grant_id      message in progress / current owner (held when idle)
//   uart_is_busy                UART busy flag, UART clock domain
//   uart_data, uart_send        byte and one-Clk write strobe into the UART FIFO
//   credits                     free UART FIFO entries (debug)
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int CREDITS = 15,
  parameter int ID_W    = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 grant_active,
  output logic [ID_W-1:0]      grant_id,
  input  logic                 uart_is_busy,
  output logic [7:0]           uart_data,
  output logic                 uart_send,
  output logic [3:0]           credits
);

  localparam logic [3:0]      CRED_MAX = 4'(CREDITS);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

  state_t          state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            active_q, active_d;
  logic [7:0]      data_q, data_d;
  logic            send_q, send_d;
  logic [3:0]      cred_q, cred_d;
  logic            busy_s1, busy_s2, busy_d;

  logic            cred_ret;
  logic            take;
  logic            can_take;
  logic [ID_W-1:0] pick;
  logic            g_vld, g_last;
  logic [7:0]      g_data;

  // A FIFO pop shows up as a rising edge of the synchronised busy flag.
  assign cred_ret = busy_s2 & ~busy_d;
  assign can_take = (state_q == STREAM) && (cred_q != 4'd0);

  // Round-robin pick: lowest valid index at or above the pointer wins;
  // otherwise the lowest valid index overall (wrap-around).
  always_comb begin
    pick = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) pick = ID_W'(j);
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) >= ptr_q)) pick = ID_W'(j);
    end
  end

  // Owner's byte stream.
  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_data = 8'h00;
    for (int j = 0; j < N_REQ; j++) begin
      if (gid_q == ID_W'(j)) begin
        g_vld  = req_valid[j];
        g_last = req_last[j];
        g_data = req_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      req_ready[j] = can_take && (gid_q == ID_W'(j));
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    data_d   = data_q;
    send_d   = 1'b0;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gid_d    = pick;
          active_d = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
          state_d  = TAG;
`else
          state_d  = STREAM;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      TAG: begin
        if (cred_q != 4'd0) begin
          data_d  = 8'hA0 | 8'(gid_q);
          send_d  = 1'b1;
          take    = 1'b1;
          state_d = STREAM;
        end
      end
`endif
      STREAM: begin
        if (g_vld && can_take) begin
          data_d = g_data;
          send_d = 1'b1;
          take   = 1'b1;
          if (g_last) begin
            active_d = 1'b0;
            ptr_d    = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous take and return cancel; a return with the counter full saturates.
  always_comb begin
    cred_d = cred_q;
    if (take && !cred_ret) begin
      cred_d = cred_q - 4'd1;
    end else if (!take && cred_ret && (cred_q != CRED_MAX)) begin
      cred_d = cred_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      ptr_q    <= '0;
      active_q <= 1'b0;
      data_q   <= 8'h00;
      send_q   <= 1'b0;
      cred_q   <= CRED_MAX;
      busy_s1  <= 1'b0;
      busy_s2  <= 1'b0;
      busy_d   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      data_q   <= data_d;
      send_q   <= send_d;
      cred_q   <= cred_d;
      busy_s1  <= uart_is_busy;
      busy_s2  <= busy_s1;
      busy_d   <= busy_s2;
    end
  end

  // A pop with every credit already home means the UART FIFO and this block disagree.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      assert (!(cred_ret && !take && (cred_q == CRED_MAX)))
        else $error("uart_tx_arbiter: credit return while credits already at maximum");
    end
  end

  assign grant_active = active_q;
  assign grant_id     = gid_q;
  assign uart_data    = data_q;
  assign uart_send    = send_q;
  assign credits      = cred_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter.
// Latency: checks are taken on the falling edge, half a cycle after the registered outputs settle.
// Backpressure: requesters hold valid until req_ready is seen; waits are bounded by cycle budgets.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;

  logic               Clk;
  logic               Rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               grant_active;
  logic [1:0]         grant_id;
  logic               uart_is_busy;
  logic [7:0]         uart_data;
  logic               uart_send;
  logic [3:0]         credits;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         send_cnt = 0;
  logic [7:0] sent_q[$];

  uart_tx_arbiter #(.N_REQ(4), .CREDITS(15), .ID_W(2)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .uart_is_busy (uart_is_busy),
    .uart_data    (uart_data),
    .uart_send    (uart_send),
    .credits      (credits)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Record every FIFO write strobe shortly after the edge that produced it.
  always @(posedge Clk) begin
    #1;
    if (uart_send === 1'b1) begin
      send_cnt++;
      sent_q.push_back(uart_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge Clk);
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    uart_is_busy = 1'b0;
    Rst_n        = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    send_cnt = 0;
    sent_q.delete();
  endtask

  // Present one byte and wait (bounded) for the handshake edge; returns at the
  // falling edge after it, where uart_send for that byte should be high.
  task automatic push(input int r, input logic [7:0] d, input logic last,
                      input int max_cyc, output bit ok);
    req_valid[r]       = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r]        = last;
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1'b1;
        @(negedge Clk);
        break;
      end
      @(negedge Clk);
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic busy_pulse();
    uart_is_busy = 1'b1;
    repeat (2) @(negedge Clk);
    uart_is_busy = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_checks++; if (grant_active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b want 0", grant_active); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    n_checks++; if (uart_send !== 1'b0) begin n_fail++; $display("FAIL rst_send: got %b want 0", uart_send); end
    n_checks++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", uart_data); end
    n_checks++; if (credits !== 4'd15) begin n_fail++; $display("FAIL rst_credits: got %0d want 15", credits); end
    req_valid = '0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_valid[1] = 1'b1; req_data[15:8] = 8'h11; req_last[1] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b want 0000", req_ready); end
    @(negedge Clk);
    n_checks++; if (grant_active !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: active=%b id=%0d want 1/1", grant_active, grant_id); end
    n_checks++; if (req_ready !== 4'b0010 || uart_send !== 1'b0) begin n_fail++; $display("FAIL single_grant_cycle: ready=%b send=%b want 0010/0", req_ready, uart_send); end
    push(1, 8'h11, 1'b0, 10, ok);
    n_checks++; if (!ok || uart_send !== 1'b1 || uart_data !== 8'h11 || credits !== 4'd14) begin n_fail++; $display("FAIL single_b0: ok=%b send=%b data=%h cred=%0d want 1/1/11/14", ok, uart_send, uart_data, credits); end
    push(1, 8'h22, 1'b0, 10, ok);
    n_checks++; if (!ok || uart_send !== 1'b1 || uart_data !== 8'h22 || credits !== 4'd13) begin n_fail++; $display("FAIL single_b1: ok=%b send=%b data=%h cred=%0d want 1/1/22/13", ok, uart_send, uart_data, credits); end
    push(1, 8'h33, 1'b1, 10, ok);
    n_checks++; if (!ok || uart_send !== 1'b1 || uart_data !== 8'h33 || credits !== 4'd12) begin n_fail++; $display("FAIL single_b2: ok=%b send=%b data=%h cred=%0d want 1/1/33/12", ok, uart_send, uart_data, credits); end
    n_checks++; if (grant_active !== 1'b0) begin n_fail++; $display("FAIL single_release: active=%b want 0", grant_active); end
    n_checks++; if (send_cnt != 3 || sent_q.size() != 3 || sent_q[0] !== 8'h11 || sent_q[1] !== 8'h22 || sent_q[2] !== 8'h33) begin n_fail++; $display("FAIL single_order: count=%0d want 3 bytes 11 22 33", send_cnt); end
    busy_pulse();
    n_checks++; if (credits !== 4'd13) begin n_fail++; $display("FAIL single_ret1: cred=%0d want 13", credits); end
    busy_pulse();
    busy_pulse();
    n_checks++; if (credits !== 4'd15) begin n_fail++; $display("FAIL single_ret3: cred=%0d want 15", credits); end
  endtask

  task automatic test_rr();
    bit ok;
    do_reset();
    req_valid[2] = 1'b1; req_data[23:16] = 8'hC2; req_last[2] = 1'b1;
    push(0, 8'h01, 1'b0, 10, ok);
    n_checks++; if (!ok || grant_id !== 2'd0) begin n_fail++; $display("FAIL rr_first: ok=%b id=%0d want 1/0", ok, grant_id); end
    push(0, 8'h02, 1'b1, 10, ok);
    n_checks++; if (!ok || grant_active !== 1'b0) begin n_fail++; $display("FAIL rr_release0: ok=%b active=%b want 1/0", ok, grant_active); end
    req_valid[0] = 1'b1; req_data[7:0] = 8'h03; req_last[0] = 1'b1;
    @(negedge Clk);
    n_checks++; if (grant_id !== 2'd2 || grant_active !== 1'b1 || req_ready !== 4'b0100) begin n_fail++; $display("FAIL rr_second: id=%0d active=%b ready=%b want 2/1/0100", grant_id, grant_active, req_ready); end
    push(2, 8'hC2, 1'b1, 10, ok);
    n_checks++; if (!ok || uart_data !== 8'hC2) begin n_fail++; $display("FAIL rr_data2: ok=%b data=%h want 1/C2", ok, uart_data); end
    @(negedge Clk);
    n_checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap: id=%0d ready=%b want 0/0001", grant_id, req_ready); end
    push(0, 8'h03, 1'b1, 10, ok);
    n_checks++; if (!ok || sent_q.size() != 4 || sent_q[0] !== 8'h01 || sent_q[1] !== 8'h02 || sent_q[2] !== 8'hC2 || sent_q[3] !== 8'h03) begin n_fail++; $display("FAIL rr_order: ok=%b count=%0d want 4 bytes 01 02 C2 03", ok, sent_q.size()); end
  endtask

  task automatic test_exhaust();
    bit ok;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      push(3, 8'(8'h40 + i), 1'b0, 10, ok);
      if (!ok) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL exh_accept: %0d of 15 bytes stalled, want 0", bad); end
    push(3, 8'h4F, 1'b0, 8, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL exh_stall: byte 16 accepted=%b want 0", ok); end
    n_checks++; if (send_cnt != 15 || req_ready !== 4'b0000 || credits !== 4'd0) begin n_fail++; $display("FAIL exh_state: sends=%0d ready=%b cred=%0d want 15/0000/0", send_cnt, req_ready, credits); end
    req_valid[3] = 1'b1; req_data[31:24] = 8'h50; req_last[3] = 1'b0;
    busy_pulse();
    busy_pulse();
    repeat (6) @(negedge Clk);
    n_checks++; if (send_cnt != 17 || credits !== 4'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL exh_refill: sends=%0d cred=%0d ready=%b want 17/0/0000", send_cnt, credits, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_simul();
    bit ok;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(1, 8'(8'h80 + i), 1'b0, 10, ok);
      if (!ok) bad++;
    end
    n_checks++; if (bad != 0 || credits !== 4'd7) begin n_fail++; $display("FAIL sim_setup: stalls=%0d cred=%0d want 0/7", bad, credits); end
    uart_is_busy = 1'b1;
    repeat (2) @(negedge Clk);
    uart_is_busy = 1'b0;
    req_valid[1] = 1'b1; req_data[15:8] = 8'h99; req_last[1] = 1'b0;
    n_checks++; if (credits !== 4'd7 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL sim_pre: cred=%0d ready=%b want 7/0010", credits, req_ready); end
    @(negedge Clk);
    req_valid[1] = 1'b0;
    n_checks++; if (credits !== 4'd7 || uart_send !== 1'b1 || uart_data !== 8'h99) begin n_fail++; $display("FAIL sim_both: cred=%0d send=%b data=%h want 7/1/99", credits, uart_send, uart_data); end
    repeat (2) @(negedge Clk);
    n_checks++; if (credits !== 4'd7) begin n_fail++; $display("FAIL sim_after: cred=%0d want 7", credits); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push(2, 8'hE0, 1'b1, 10, ok);
    push(2, 8'hD0, 1'b0, 10, ok);
    push(2, 8'hD1, 1'b0, 10, ok);
    req_valid[2] = 1'b1; req_data[23:16] = 8'hD2;
    n_checks++; if (!ok || grant_id !== 2'd2 || grant_active !== 1'b1 || credits !== 4'd12) begin n_fail++; $display("FAIL mid_pre: ok=%b id=%0d active=%b cred=%0d want 1/2/1/12", ok, grant_id, grant_active, credits); end
    Rst_n = 1'b0;
    #1;
    n_checks++; if (grant_active !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_grant: active=%b id=%0d ready=%b want 0/0/0000", grant_active, grant_id, req_ready); end
    n_checks++; if (uart_send !== 1'b0 || uart_data !== 8'h00 || credits !== 4'd15) begin n_fail++; $display("FAIL mid_uart: send=%b data=%h cred=%0d want 0/00/15", uart_send, uart_data, credits); end
    @(negedge Clk);
    Rst_n = 1'b1;
    req_valid = 4'b1010;
    @(negedge Clk);
    n_checks++; if (grant_id !== 2'd1 || grant_active !== 1'b1) begin n_fail++; $display("FAIL mid_regrant: id=%0d active=%b want 1/1", grant_id, grant_active); end
    req_valid = '0;
  endtask

`ifdef UART_TX_ARB_TAG_EN
  task automatic test_tag();
    bit ok;
    do_reset();
    push(3, 8'h5A, 1'b1, 10, ok);
    n_checks++; if (!ok || sent_q.size() != 2 || sent_q[0] !== 8'hA3 || sent_q[1] !== 8'h5A) begin n_fail++; $display("FAIL tag_seq: ok=%b count=%0d want 2 bytes A3 5A", ok, sent_q.size()); end
    n_checks++; if (credits !== 4'd13) begin n_fail++; $display("FAIL tag_credits: cred=%0d want 13", credits); end
  endtask
`endif

  initial begin
    Rst_n        = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    uart_is_busy = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    Rst_n = 1'b1;
    test_single();
    test_rr();
    test_exhaust();
    test_simul();
    test_reset_mid();
`ifdef UART_TX_ARB_TAG_EN
    test_tag();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
